fmul_36bit_mantissa_mul: RTL



---
 rtl/fmul_36bit_mantissa_mul_if.sv | 38 +++
 rtl/fmul_36bit_mantissa_mul.sv | 132 +++++++++++++
 2 files changed

// File: rtl/fmul_36bit_mantissa_mul_if.sv
// Operand/result bus for the first multiplier stage.
// master: upstream operand source plus downstream result sink (bench side).
// slave:  the mantissa multiplier stage itself.
interface fmul_36bit_mantissa_mul_if;
   // Upstream side
   logic        iDATA_VALID;
   logic        oDATA_BUSY;
   logic [35:0] iDATA_A;
   logic [35:0] iDATA_B;
   // Downstream side
   logic        oDATA_VALID;
   logic        iDATA_BUSY;
   logic        oDATA_SIGN;
   logic [12:0] oDATA_EXP;
   logic [49:0] oDATA_FRACT;
   logic        oDATA_EXCEPT_EXP_A0;
   logic        oDATA_EXCEPT_EXP_B0;
   logic        oDATA_EXCEPT_EXP_A1;
   logic        oDATA_EXCEPT_EXP_B1;
   logic        oDATA_EXCEPT_FRACT_A0;
   logic        oDATA_EXCEPT_FRACT_B0;

   modport master (
      output iDATA_VALID, iDATA_A, iDATA_B, iDATA_BUSY,
      input  oDATA_BUSY, oDATA_VALID, oDATA_SIGN, oDATA_EXP, oDATA_FRACT,
      input  oDATA_EXCEPT_EXP_A0, oDATA_EXCEPT_EXP_B0,
      input  oDATA_EXCEPT_EXP_A1, oDATA_EXCEPT_EXP_B1,
      input  oDATA_EXCEPT_FRACT_A0, oDATA_EXCEPT_FRACT_B0
   );

   modport slave (
      input  iDATA_VALID, iDATA_A, iDATA_B, iDATA_BUSY,
      output oDATA_BUSY, oDATA_VALID, oDATA_SIGN, oDATA_EXP, oDATA_FRACT,
      output oDATA_EXCEPT_EXP_A0, oDATA_EXCEPT_EXP_B0,
      output oDATA_EXCEPT_EXP_A1, oDATA_EXCEPT_EXP_B1,
      output oDATA_EXCEPT_FRACT_A0, oDATA_EXCEPT_FRACT_B0
   );
endinterface

// File: rtl/fmul_36bit_mantissa_mul.sv
// First arithmetic stage of the 36-bit FP multiplier: sign, biased exponent
// sum, exact 50-bit mantissa product and operand exception flags.
// Two-stage pipeline, stalled as a whole by the downstream busy.
// Optional macro FMUL36_DAZ_EN: operands with exp == 0 multiply as zero.
module fmul_36bit_mantissa_mul #(
   parameter int unsigned P_BIAS = 1023
) (
   input logic                      iCLOCK,
   input logic                      inRESET,
   input logic                      iRESET_SYNC,
   fmul_36bit_mantissa_mul_if.slave bus
);

   localparam logic [12:0] LP_BIAS = 13'(P_BIAS);

   // Operand fields
   logic [10:0] exp_a, exp_b;
   logic [23:0] fract_a, fract_b;
   logic [24:0] mant_a, mant_b;
   logic [12:0] exp_sum;
   logic [37:0] p_lo;
   logic [36:0] p_hi;
   logic [5:0]  flags;

   // Stage 1 registers
   logic        s1_valid_q;
   logic        s1_sign_q;
   logic [12:0] s1_exp_q;
   logic [37:0] s1_p_lo_q;
   logic [36:0] s1_p_hi_q;
   logic [5:0]  s1_flags_q;   // {a0, b0, a1, b1, fract_a0, fract_b0}

   // Stage 2 registers
   logic        s2_valid_q;
   logic        s2_sign_q;
   logic [12:0] s2_exp_q;
   logic [49:0] s2_fract_q;
   logic [5:0]  s2_flags_q;

   logic [49:0] fract_sum;

   // Unpack operands, build mantissas and the two partial products
   always_comb begin
      exp_a   = bus.iDATA_A[34:24];
      exp_b   = bus.iDATA_B[34:24];
      fract_a = bus.iDATA_A[23:0];
      fract_b = bus.iDATA_B[23:0];
`ifdef FMUL36_DAZ_EN
      mant_a  = (exp_a != 11'h000) ? {1'b1, fract_a} : 25'h0;
      mant_b  = (exp_b != 11'h000) ? {1'b1, fract_b} : 25'h0;
`else
      mant_a  = {(exp_a != 11'h000), fract_a};
      mant_b  = {(exp_b != 11'h000), fract_b};
`endif
      exp_sum = {2'b00, exp_a} + {2'b00, exp_b} - LP_BIAS;
      // Split B so each partial product stays narrow; recombined exactly in stage 2
      p_lo    = {13'd0, mant_a} * {25'd0, mant_b[12:0]};
      p_hi    = {12'd0, mant_a} * {25'd0, mant_b[24:13]};
      flags   = {(exp_a == 11'h000), (exp_b == 11'h000),
                 (exp_a == 11'h7FF), (exp_b == 11'h7FF),
                 (fract_a == 24'h0), (fract_b == 24'h0)};
   end

   // Stage 1: capture sign, exponent, partial products and flags
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         s1_valid_q <= 1'b0;
         s1_sign_q  <= 1'b0;
         s1_exp_q   <= '0;
         s1_p_lo_q  <= '0;
         s1_p_hi_q  <= '0;
         s1_flags_q <= '0;
      end else if (iRESET_SYNC) begin
         s1_valid_q <= 1'b0;
         s1_sign_q  <= 1'b0;
         s1_exp_q   <= '0;
         s1_p_lo_q  <= '0;
         s1_p_hi_q  <= '0;
         s1_flags_q <= '0;
      end else if (!bus.iDATA_BUSY) begin
         // Data loads regardless of valid; consumers qualify on valid
         s1_valid_q <= bus.iDATA_VALID;
         s1_sign_q  <= bus.iDATA_A[35] ^ bus.iDATA_B[35];
         s1_exp_q   <= exp_sum;
         s1_p_lo_q  <= p_lo;
         s1_p_hi_q  <= p_hi;
         s1_flags_q <= flags;
      end
   end

   // Recombine partial products into the exact 50-bit product
   always_comb begin
      fract_sum = {12'd0, s1_p_lo_q} + {s1_p_hi_q, 13'd0};
   end

   // Stage 2: register the full product, pass the other fields through
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         s2_valid_q <= 1'b0;
         s2_sign_q  <= 1'b0;
         s2_exp_q   <= '0;
         s2_fract_q <= '0;
         s2_flags_q <= '0;
      end else if (iRESET_SYNC) begin
         s2_valid_q <= 1'b0;
         s2_sign_q  <= 1'b0;
         s2_exp_q   <= '0;
         s2_fract_q <= '0;
         s2_flags_q <= '0;
      end else if (!bus.iDATA_BUSY) begin
         s2_valid_q <= s1_valid_q;
         s2_sign_q  <= s1_sign_q;
         s2_exp_q   <= s1_exp_q;
         s2_fract_q <= fract_sum;
         s2_flags_q <= s1_flags_q;
      end
   end

   // Stall passes straight through; the whole pipe freezes together
   assign bus.oDATA_BUSY            = bus.iDATA_BUSY;
   assign bus.oDATA_VALID           = s2_valid_q;
   assign bus.oDATA_SIGN            = s2_sign_q;
   assign bus.oDATA_EXP             = s2_exp_q;
   assign bus.oDATA_FRACT           = s2_fract_q;
   assign bus.oDATA_EXCEPT_EXP_A0   = s2_flags_q[5];
   assign bus.oDATA_EXCEPT_EXP_B0   = s2_flags_q[4];
   assign bus.oDATA_EXCEPT_EXP_A1   = s2_flags_q[3];
   assign bus.oDATA_EXCEPT_EXP_B1   = s2_flags_q[2];
   assign bus.oDATA_EXCEPT_FRACT_A0 = s2_flags_q[1];
   assign bus.oDATA_EXCEPT_FRACT_B0 = s2_flags_q[0];

endmodule
